booth_r4_seq_mult: RTL and testbench

//  Iterative radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH product.

---
 rtl/booth_r4_seq_mult.sv | 118 +++++++++++
 tb/tb_booth_r4_seq_mult.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/booth_r4_seq_mult.sv
// Iterative radix-4 Booth multiplier: one recoded digit per clock, one shared adder.
// Define BOOTH_UNSIGNED_EN to add the sgn port and unsigned operation (one extra digit).
module booth_r4_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
`ifdef BOOTH_UNSIGNED_EN
  input  logic                 sgn,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int AW = 2*WIDTH + 2;
  localparam int BW = WIDTH + 3;
  localparam int CW = $clog2(WIDTH/2 + 2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         r_state;
  logic               r_busy;
  logic               r_done;
  logic [2*WIDTH-1:0] r_prod;
  logic [AW-1:0]      r_acc;
  logic [AW-1:0]      r_mc;
  logic [BW-1:0]      r_b;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      r_last;

  logic               w_sgn;
  logic [CW-1:0]      w_last;
  logic [AW-1:0]      w_a_ext;
  logic [BW-1:0]      w_b_ext;
  logic               w_neg;
  logic               w_one;
  logic               w_two;
  logic [AW-1:0]      w_mag;
  logic [AW-1:0]      w_sum;

`ifdef BOOTH_UNSIGNED_EN
  assign w_sgn  = sgn;
  assign w_last = sgn ? CW'(WIDTH/2 - 1) : CW'(WIDTH/2);
`else
  assign w_sgn  = 1'b1;
  assign w_last = CW'(WIDTH/2 - 1);
`endif

  // Multiplier carries an appended b[-1]=0 bit so the low 3 bits are always the current digit window.
  assign w_a_ext = {{(AW-WIDTH){w_sgn & a[WIDTH-1]}}, a};
  assign w_b_ext = {{2{w_sgn & b[WIDTH-1]}}, b, 1'b0};

  assign w_neg = r_b[2] & ~(r_b[1] & r_b[0]);
  assign w_one = r_b[1] ^ r_b[0];
  assign w_two = (r_b[2:0] == 3'b011) || (r_b[2:0] == 3'b100);
  assign w_mag = w_one ? r_mc : (w_two ? (r_mc << 1) : '0);

  // Multiplicand is pre-shifted by 2 each digit, so the partial product lands at weight 4^i.
  assign w_sum = r_acc + (w_mag ^ {AW{w_neg}}) + {{(AW-1){1'b0}}, w_neg};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_prod  <= '0;
      r_acc   <= '0;
      r_mc    <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_last  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_mc    <= w_a_ext;
            r_b     <= w_b_ext;
            r_last  <= w_last;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_acc <= w_sum;
          r_mc  <= r_mc << 2;
          r_b   <= r_b >> 2;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == r_last) begin
            r_prod  <= w_sum[2*WIDTH-1:0];
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_prod;

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Bench for booth_r4_seq_mult (WIDTH=8): vector table, back-to-back issue, mid-run reset, random sweep.
// Expected products are queued at issue and checked on each done pulse.
module tb_booth_r4_seq_mult;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        sgn;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[12];

  booth_r4_seq_mult #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
`ifdef BOOTH_UNSIGNED_EN
    .sgn     (sgn),
`endif
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
    logic [15:0] xe;
    logic [15:0] ye;
    xe = s ? {{8{x[7]}}, x} : {8'h00, x};
    ye = s ? {{8{y[7]}}, y} : {8'h00, y};
    return xe * ye;
  endfunction

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      checks++;
      if (busy) begin
        errors++;
        $display("FAIL busy_and_done busy=%0b done=%0b required busy=0", busy, done);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done product=%h required no done pulse", product);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (product !== e) begin
          errors++;
          $display("FAIL product got %h required %h", product, e);
        end else begin
          $display("ok   product %h", product);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, got, req);
    end
  endtask

  task automatic do_mult(input logic [7:0] x, input logic [7:0] y, input logic s,
                         input logic [15:0] e, input int nd);
    int nb;
    bit got;
    @(negedge clk);
    a = x; b = y; sgn = s; start = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    nb = 0; got = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) begin got = 1; break; end
      if (busy) nb++;
      @(negedge clk);
    end
    check("done_seen", 32'(got), 32'd1);
    check("busy_cycles", 32'(nb), 32'(nd));
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("product_held", 32'(product), 32'(e));
    $display("op   a=%h b=%h sgn=%0b busy_cycles=%0d", x, y, s, nb);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{8'h80, 8'h80, 16'h4000};
    vecs[1]  = '{8'h7F, 8'h80, 16'hC080};
    vecs[2]  = '{8'hFF, 8'hFF, 16'h0001};
    vecs[3]  = '{8'h55, 8'h33, 16'h10EF};
    vecs[4]  = '{8'h03, 8'h05, 16'h000F};
    vecs[5]  = '{8'h00, 8'h7F, 16'h0000};
    vecs[6]  = '{8'h01, 8'h80, 16'hFF80};
    vecs[7]  = '{8'h7F, 8'h7F, 16'h3F01};
    vecs[8]  = '{8'h80, 8'h01, 16'hFF80};
    vecs[9]  = '{8'hFE, 8'h03, 16'hFFFA};
    vecs[10] = '{8'h80, 8'h7F, 16'hC080};
    vecs[11] = '{8'h12, 8'hF6, 16'hFF4C};

    reset = 1'b1; start = 1'b0; a = '0; b = '0; sgn = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", 32'(product), 32'd0);

    for (int i = 0; i < 12; i++)
      do_mult(vecs[i].a, vecs[i].b, 1'b1, vecs[i].p, 4);

`ifdef BOOTH_UNSIGNED_EN
    do_mult(8'hFF, 8'hFF, 1'b0, 16'hFE01, 5);
    do_mult(8'hFF, 8'hFF, 1'b1, 16'h0001, 4);
    do_mult(8'h80, 8'h80, 1'b0, 16'h4000, 5);
`endif

    // Back-to-back: start held high, operands garbled while running.
    @(negedge clk);
    start = 1'b1; sgn = 1'b1;
    a = vecs[0].a; b = vecs[0].b;
    exp_q.push_back(vecs[0].p);
    for (int i = 1; i <= 6; i++) begin
      bit got;
      int cyc;
      got = 0; cyc = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        cyc = c;
        if (done) begin got = 1; break; end
        a = 8'($urandom); b = 8'($urandom);
      end
      check("b2b_done_seen", 32'(got), 32'd1);
      check("b2b_interval", 32'(cyc + 1), 32'd5);
      $display("b2b  result %0d interval=%0d", i - 1, cyc + 1);
      if (i < 6) begin
        a = vecs[i].a; b = vecs[i].b;
        exp_q.push_back(vecs[i].p);
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);

    // Reset on the second RUN cycle: aborted op must not produce done.
    a = 8'h12; b = 8'h34; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort_running", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_product", 32'(product), 32'd0);
    repeat (8) @(negedge clk);
    $display("abort no done pulse observed window complete");
    do_mult(8'h03, 8'h05, 1'b1, 16'h000F, 4);

    // Random sweep against the behavioural model.
    for (int i = 0; i < 200; i++) begin
      logic [7:0] x;
      logic [7:0] y;
      logic s;
      x = 8'($urandom); y = 8'($urandom);
`ifdef BOOTH_UNSIGNED_EN
      s = 1'($urandom);
`else
      s = 1'b1;
`endif
      do_mult(x, y, s, model(x, y, s), s ? 4 : 5);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
